l1_dma_bus_arbiter: RTL and testbench

- Shares the single bus_unit request interface between two requesters: M0 = L1 cache controller and M1 = cDMA engine.
- The requests are write-through, single read and line read.
- Sits between the L1 cache/cDMA and the MMU/bus_unit path.
- Registered grant state machine; fixed priority to M0 with a starvation guard for M1.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/l1_dma_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_l1_dma_bus_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the L1/cDMA bus arbiter: FSM states, one-hot grants
// and the default starvation limit.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int unsigned STARVE_LIMIT_DEF = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/l1_dma_bus_arbiter.sv
// Two-master arbiter (M0 = L1 cache, M1 = cDMA) in front of bus_unit: fixed
// M0 priority, M1 starvation guard. Optional M0 bus lock under ARB_LOCK_EN.
module l1_dma_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW           = 24,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned LINE_CNT_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_wt_req,
  input  logic                  m0_rd_req,
  input  logic                  m0_rdline_req,
  input  logic [AW-1:0]         m0_pa,
  input  logic [7:0]            m0_wdata,
`ifdef ARB_LOCK_EN
  input  logic                  m0_lock,
`endif
  input  logic                  m1_wt_req,
  input  logic                  m1_rd_req,
  input  logic                  m1_rdline_req,
  input  logic [AW-1:0]         m1_pa,
  input  logic [7:0]            m1_wdata,
  output logic                  m0_line_write,
  output logic                  m0_trans_rdy,
  output logic                  m0_bus_error,
  output logic                  m1_line_write,
  output logic                  m1_trans_rdy,
  output logic                  m1_bus_error,
  output logic [7:0]            line_data,
  output logic [LINE_CNT_W-1:0] addr_count,
  output logic                  bus_wt_req,
  output logic                  bus_rd_req,
  output logic                  bus_rdline_req,
  output logic [AW-1:0]         bus_pa,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_line_data,
  input  logic [LINE_CNT_W-1:0] bus_addr_count,
  input  logic                  bus_line_write,
  input  logic                  bus_trans_rdy,
  input  logic                  bus_error,
  output logic [1:0]            grant,
  output logic                  arb_busy
);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q,  busy_d;
  logic [7:0] scnt_q,  scnt_d;

  logic req0, req1, done, starve, lock_hold, lock_active;

  assign req0   = m0_wt_req | m0_rd_req | m0_rdline_req;
  assign req1   = m1_wt_req | m1_rd_req | m1_rdline_req;
  assign done   = bus_trans_rdy | bus_error;
  assign starve = req1 && (scnt_q >= 8'(STARVE_LIMIT));

`ifdef ARB_LOCK_EN
  // A locked M0 keeps ownership across completions for atomic RMW sequences.
  assign lock_active = (state_q == ST_OWN0) && m0_lock;
  assign lock_hold   = lock_active && req0;
`else
  assign lock_active = 1'b0;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && !starve) state_d = ST_OWN0;
        else if (req1)       state_d = ST_OWN1;
      end
      ST_OWN0: if (done && !lock_hold) state_d = ST_IDLE;
      ST_OWN1: if (done)               state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_OWN0: grant_d = GRANT_M0;
      ST_OWN1: grant_d = GRANT_M1;
      default: grant_d = GRANT_NONE;
    endcase
    busy_d = (state_d != ST_IDLE);

    if (!req1)                                        scnt_d = '0;
    else if (state_d == ST_OWN1 && state_q != ST_OWN1) scnt_d = '0;
    else if (lock_active || grant_q[1])               scnt_d = scnt_q;
    else                                              scnt_d = sat_inc8(scnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_NONE;
      busy_q  <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      scnt_q  <= scnt_d;
    end
  end

  // Request path follows the owner; responses reach only the owner.
  always_comb begin
    bus_wt_req     = 1'b0;
    bus_rd_req     = 1'b0;
    bus_rdline_req = 1'b0;
    bus_pa         = '0;
    bus_wdata      = '0;
    m0_line_write  = 1'b0;
    m0_trans_rdy   = 1'b0;
    m0_bus_error   = 1'b0;
    m1_line_write  = 1'b0;
    m1_trans_rdy   = 1'b0;
    m1_bus_error   = 1'b0;
    unique case (state_q)
      ST_OWN0: begin
        bus_wt_req     = m0_wt_req;
        bus_rd_req     = m0_rd_req;
        bus_rdline_req = m0_rdline_req;
        bus_pa         = m0_pa;
        bus_wdata      = m0_wdata;
        m0_line_write  = bus_line_write;
        m0_trans_rdy   = bus_trans_rdy;
        m0_bus_error   = bus_error;
      end
      ST_OWN1: begin
        bus_wt_req     = m1_wt_req;
        bus_rd_req     = m1_rd_req;
        bus_rdline_req = m1_rdline_req;
        bus_pa         = m1_pa;
        bus_wdata      = m1_wdata;
        m1_line_write  = bus_line_write;
        m1_trans_rdy   = bus_trans_rdy;
        m1_bus_error   = bus_error;
      end
      default: ;
    endcase
  end

  assign line_data  = bus_line_data;
  assign addr_count = bus_addr_count;
  assign grant      = grant_q;
  assign arb_busy   = busy_q;

endmodule

// File: tb/tb_l1_dma_bus_arbiter.sv
// Directed, table-driven bench for l1_dma_bus_arbiter; lock sequence is
// built only when ARB_LOCK_EN is defined.
module tb_l1_dma_bus_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned LW = 7;
  localparam logic [23:0] PA0 = 24'h001234;
  localparam logic [23:0] PA1 = 24'h00ABCD;
  localparam logic [7:0]  WD0 = 8'h5A;
  localparam logic [7:0]  WD1 = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic m0_wt_req, m0_rd_req, m0_rdline_req;
  logic m1_wt_req, m1_rd_req, m1_rdline_req;
  logic [AW-1:0] m0_pa, m1_pa, bus_pa;
  logic [7:0] m0_wdata, m1_wdata, bus_wdata, line_data, bus_line_data;
  logic m0_line_write, m0_trans_rdy, m0_bus_error;
  logic m1_line_write, m1_trans_rdy, m1_bus_error;
  logic [LW-1:0] addr_count, bus_addr_count;
  logic bus_wt_req, bus_rd_req, bus_rdline_req;
  logic bus_line_write, bus_trans_rdy, bus_error;
  logic [1:0] grant;
  logic arb_busy;
`ifdef ARB_LOCK_EN
  logic m0_lock;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  l1_dma_bus_arbiter #(.AW(AW), .STARVE_LIMIT(8), .LINE_CNT_W(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_wt_req(m0_wt_req), .m0_rd_req(m0_rd_req), .m0_rdline_req(m0_rdline_req),
    .m0_pa(m0_pa), .m0_wdata(m0_wdata),
`ifdef ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m1_wt_req(m1_wt_req), .m1_rd_req(m1_rd_req), .m1_rdline_req(m1_rdline_req),
    .m1_pa(m1_pa), .m1_wdata(m1_wdata),
    .m0_line_write(m0_line_write), .m0_trans_rdy(m0_trans_rdy), .m0_bus_error(m0_bus_error),
    .m1_line_write(m1_line_write), .m1_trans_rdy(m1_trans_rdy), .m1_bus_error(m1_bus_error),
    .line_data(line_data), .addr_count(addr_count),
    .bus_wt_req(bus_wt_req), .bus_rd_req(bus_rd_req), .bus_rdline_req(bus_rdline_req),
    .bus_pa(bus_pa), .bus_wdata(bus_wdata),
    .bus_line_data(bus_line_data), .bus_addr_count(bus_addr_count),
    .bus_line_write(bus_line_write), .bus_trans_rdy(bus_trans_rdy), .bus_error(bus_error),
    .grant(grant), .arb_busy(arb_busy)
  );

  // req fields: {wt, rd, rdline}; response fields: {line_write, trans_rdy, bus_error}
  typedef struct packed {
    logic        rst;
    logic [2:0]  m0r;
    logic [2:0]  m1r;
    logic        rdy;
    logic        err;
    logic        lw;
    logic [1:0]  g;
    logic        busy;
    logic [2:0]  breq;
    logic [23:0] pa;
    logic [7:0]  wd;
    logic [2:0]  r0;
    logic [2:0]  r1;
  } vec_t;

  localparam int unsigned NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [2:0] a, input logic [2:0] b,
                              input logic rd, input logic er, input logic l,
                              input logic [1:0] g, input logic bz, input logic [2:0] bq,
                              input logic [23:0] pa, input logic [7:0] wd,
                              input logic [2:0] r0, input logic [2:0] r1);
    vec_t v;
    v.rst = r; v.m0r = a; v.m1r = b; v.rdy = rd; v.err = er; v.lw = l;
    v.g = g; v.busy = bz; v.breq = bq; v.pa = pa; v.wd = wd; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] b,
                       input logic rd, input logic er, input logic l);
    rst = r;
    {m0_wt_req, m0_rd_req, m0_rdline_req} = a;
    {m1_wt_req, m1_rd_req, m1_rdline_req} = b;
    bus_trans_rdy  = rd;
    bus_error      = er;
    bus_line_write = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[1]  = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b000, 3'b000);
    vecs[2]  = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b000, 3'b000);
    vecs[3]  = mk(0, 3'b010, 3'b000, 1, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b010, 3'b000);
    vecs[4]  = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[5]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[6]  = mk(0, 3'b000, 3'b100, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[7]  = mk(0, 3'b000, 3'b100, 0, 0, 0, 2'b10, 1, 3'b100, PA1,   WD1,  3'b000, 3'b000);
    vecs[8]  = mk(0, 3'b000, 3'b100, 0, 1, 0, 2'b10, 1, 3'b100, PA1,   WD1,  3'b000, 3'b001);
    vecs[9]  = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[10] = mk(0, 3'b100, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[11] = mk(0, 3'b100, 3'b000, 0, 0, 0, 2'b01, 1, 3'b100, PA0,   WD0,  3'b000, 3'b000);
    vecs[12] = mk(0, 3'b100, 3'b000, 1, 1, 0, 2'b01, 1, 3'b100, PA0,   WD0,  3'b011, 3'b000);
    vecs[13] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[14] = mk(0, 3'b001, 3'b001, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[15] = mk(0, 3'b001, 3'b001, 0, 0, 1, 2'b01, 1, 3'b001, PA0,   WD0,  3'b100, 3'b000);
    vecs[16] = mk(0, 3'b001, 3'b001, 1, 0, 1, 2'b01, 1, 3'b001, PA0,   WD0,  3'b110, 3'b000);
    vecs[17] = mk(0, 3'b000, 3'b001, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[18] = mk(0, 3'b000, 3'b001, 1, 0, 0, 2'b10, 1, 3'b001, PA1,   WD1,  3'b000, 3'b010);
    vecs[19] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[20] = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[21] = mk(1, 3'b010, 3'b000, 0, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b000, 3'b000);
    vecs[22] = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[23] = mk(0, 3'b010, 3'b000, 0, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b000, 3'b000);
    vecs[24] = mk(0, 3'b010, 3'b000, 1, 0, 0, 2'b01, 1, 3'b010, PA0,   WD0,  3'b010, 3'b000);
    vecs[25] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[26] = mk(0, 3'b000, 3'b010, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);
    vecs[27] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b10, 1, 3'b000, PA1,   WD1,  3'b000, 3'b000);
    vecs[28] = mk(0, 3'b000, 3'b000, 1, 0, 0, 2'b10, 1, 3'b000, PA1,   WD1,  3'b000, 3'b010);
    vecs[29] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 24'h0, 8'h0, 3'b000, 3'b000);

    m0_pa = PA0; m1_pa = PA1; m0_wdata = WD0; m1_wdata = WD1;
    bus_line_data = 8'h00; bus_addr_count = '0;
`ifdef ARB_LOCK_EN
    m0_lock = 1'b0;
`endif

    // Reset with a pending M0 request: arbiter must stay idle.
    @(negedge clk); drive(1, 3'b010, 3'b010, 0, 0, 0);
    @(negedge clk); drive(1, 3'b010, 3'b010, 0, 0, 0);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(arb_busy), 32'h0);
    check("rst_busreq", 32'({bus_wt_req, bus_rd_req, bus_rdline_req}), 32'h0);
    check("rst_rsp", 32'({m0_trans_rdy, m1_trans_rdy, m0_bus_error, m1_bus_error}), 32'h0);
    @(negedge clk); drive(0, 3'b000, 3'b000, 0, 0, 0);

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].m0r, vecs[i].m1r, vecs[i].rdy, vecs[i].err, vecs[i].lw);
      #1;
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("v%0d_busy", i), 32'(arb_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_busreq", i), 32'({bus_wt_req, bus_rd_req, bus_rdline_req}), 32'(vecs[i].breq));
      check($sformatf("v%0d_pa", i), 32'(bus_pa), 32'(vecs[i].pa));
      check($sformatf("v%0d_wdata", i), 32'(bus_wdata), 32'(vecs[i].wd));
      check($sformatf("v%0d_m0rsp", i), 32'({m0_line_write, m0_trans_rdy, m0_bus_error}), 32'(vecs[i].r0));
      check($sformatf("v%0d_m1rsp", i), 32'({m1_line_write, m1_trans_rdy, m1_bus_error}), 32'(vecs[i].r1));
    end

    // Simultaneous line reads, 16 beats to M0, then one idle cycle, then M1.
    @(negedge clk); drive(0, 3'b001, 3'b001, 0, 0, 0); #1;
    check("line_arb_grant", 32'(grant), 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus_addr_count = LW'(k);
      bus_line_data  = 8'(8'h30 + k);
      drive(0, 3'b001, 3'b001, (k == 15), 0, 1);
      #1;
      check($sformatf("beat%0d_grant", k), 32'(grant), 32'h1);
      check($sformatf("beat%0d_m0lw", k), 32'({m0_line_write, m0_trans_rdy}), (k == 15) ? 32'h3 : 32'h2);
      check($sformatf("beat%0d_m1rsp", k), 32'({m1_line_write, m1_trans_rdy, m1_bus_error}), 32'h0);
      check($sformatf("beat%0d_cnt", k), 32'(addr_count), 32'(k));
      check($sformatf("beat%0d_data", k), 32'(line_data), 32'(8'h30 + k));
    end
    @(negedge clk); drive(0, 3'b000, 3'b001, 0, 0, 0); #1;
    check("line_idle_gap", 32'(grant), 32'h0);
    @(negedge clk); drive(0, 3'b000, 3'b001, 1, 0, 0); #1;
    check("line_m1_grant", 32'(grant), 32'h2);
    check("line_m1_rdy", 32'(m1_trans_rdy), 32'h1);
    @(negedge clk); drive(0, 3'b000, 3'b000, 0, 0, 0);

    // M0 back-to-back single-cycle reads with M1 waiting: M1 wins at scnt 8.
    for (int c = 0; c < 12; c++) begin
      logic [1:0] exp_g;
      exp_g = (c == 9) ? 2'b10 : ((c % 2 == 1) ? 2'b01 : 2'b00);
      @(negedge clk);
      drive(0, 3'b010, 3'b010, (exp_g != 2'b00), 0, 0);
      #1;
      check($sformatf("starve_c%0d_grant", c), 32'(grant), 32'(exp_g));
    end
    @(negedge clk); drive(0, 3'b000, 3'b000, 0, 0, 0);
    @(negedge clk); #1;
    check("starve_end_idle", 32'(grant), 32'h0);

`ifdef ARB_LOCK_EN
    // Locked M0 keeps the bus across completions; M1's wait does not accrue.
    for (int c = 0; c < 14; c++) begin
      logic [1:0] exp_g;
      exp_g = (c == 0 || c == 12) ? 2'b00 : 2'b01;
      @(negedge clk);
      m0_lock = (c >= 1 && c <= 10);
      drive(0, 3'b010, 3'b010, (exp_g == 2'b01), 0, 0);
      #1;
      check($sformatf("lock_c%0d_grant", c), 32'(grant), 32'(exp_g));
    end
    @(negedge clk); m0_lock = 1'b0; drive(0, 3'b000, 3'b000, 0, 0, 0);
    @(negedge clk); #1;
    check("lock_end_idle", 32'(grant), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
